// File: rtl/udp_pkg.sv
// Shared types and helpers for the UDP receive parser: FSM encoding,
// byte-keep mask generation and one's-complement folding.
package udp_pkg;

  localparam int         UDP_HDR_BYTES = 8;
  localparam logic [7:0] IP_PROTO_UDP  = 8'h11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR2    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } udp_state_e;

  // MSB-aligned mask with one bit per remaining byte, capped at 8 bytes
  function automatic logic [7:0] keep_mask(input logic [15:0] bytes_left);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m[7-i] = (bytes_left > 16'(i));
    end
    return m;
  endfunction

  // Two end-around folds bring any 20-bit partial sum back to 16 bits
  function automatic logic [15:0] csum_fold(input logic [19:0] s);
    logic [16:0] f;
    f = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    return f[15:0] + {15'd0, f[16]};
  endfunction

endpackage

// File: rtl/udp_csum_accum.sv
// Running one's-complement accumulator over DATA_W/16 masked halfword lanes.
// pass_o reflects the sum including the word presented this cycle.
module udp_csum_accum
  import udp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [15:0]       init_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W/8-1:0] keep_i,
  input  logic [15:0]       rx_csum_i,
  output logic              pass_o
);

  localparam int LANES = DATA_W / 16;
  localparam int NB    = DATA_W / 8;

  logic [15:0] acc_q, acc_d;
  logic [15:0] sum_next_s;

  // Add this cycle's masked lanes onto either the pseudo-header seed or the running sum
  always_comb begin
    logic [19:0] sum;
    logic [15:0] lane;
    sum  = load_i ? {4'd0, init_i} : {4'd0, acc_q};
    lane = 16'h0000;
    for (int l = 0; l < LANES; l++) begin
      lane = word_i[DATA_W-1-16*l -: 16]
             & {{8{keep_i[NB-1-2*l]}}, {8{keep_i[NB-2-2*l]}}};
      sum  = sum + {4'd0, lane};
    end
    sum_next_s = csum_fold(sum);
    acc_d      = en_i ? sum_next_s : acc_q;
  end

  assign pass_o = (sum_next_s == 16'hFFFF) || (rx_csum_i == 16'h0000);

  // Accumulator register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= 16'h0000;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/udp_rx_parser.sv
// UDP receive parser: header extraction, payload streaming with byte-keep,
// length checks and listen-port steering. Checksum verification is built
// only when UDP_RX_CHECKSUM_EN is defined.
module udp_rx_parser
  import udp_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_PORTS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       data,
  input  logic [31:0]             src_ip,
  input  logic [31:0]             dest_ip,
  input  logic [15:0]             len_udp,
  input  logic [NUM_PORTS*16-1:0] listen_ports,
  output logic [15:0]             src_port,
  output logic [15:0]             dest_port,
  output logic [15:0]             len_data,
  output logic [DATA_W-1:0]       data_udp,
  output logic [DATA_W/8-1:0]     data_keep,
  output logic                    wr_en,
  output logic [NUM_PORTS-1:0]    port_hit,
  output logic                    fin,
  output logic                    ok,
  output logic                    err_len
);

  localparam int          NB      = DATA_W / 8;
  localparam logic [15:0] NB16    = 16'(DATA_W / 8);
  localparam bit          ONE_HDR = (DATA_W == 64);

  udp_state_e state_q, state_d;
  logic [15:0] bytes_left_q, bytes_left_d, len_udp_q, len_udp_d;
  logic [31:0] hdr0_q, hdr0_d;
  logic        len_err_q, len_err_d;
  logic [15:0] src_port_q, src_port_d, dest_port_q, dest_port_d, len_data_q, len_data_d;
  logic [DATA_W-1:0]    data_udp_q, data_udp_d;
  logic [NB-1:0]        data_keep_q, data_keep_d;
  logic [NUM_PORTS-1:0] port_hit_q, port_hit_d, hit_s;
  logic wr_en_q, wr_en_d, fin_q, fin_d, ok_q, ok_d, err_len_q, err_len_d;

  logic [31:0]   hdr_sel_s;
  logic [15:0]   start_bytes_s, bytes_ref_s, bytes_next_s, len_ref_s;
  logic          hdr_last_s, pay_s, abort_s, hdr_err_s, short_ref_s, csum_pass_s;
  logic [7:0]    keep8_s;
  logic [NB-1:0] keep_s;

  assign hdr_sel_s     = ONE_HDR ? data[DATA_W-1 -: 32] : hdr0_q;
  assign start_bytes_s = (len_udp < 16'd8) ? 16'd0 : len_udp - 16'd8;
  assign bytes_ref_s   = ONE_HDR ? start_bytes_s : bytes_left_q;
  assign len_ref_s     = ONE_HDR ? len_udp : len_udp_q;
  assign short_ref_s   = ONE_HDR ? (len_udp < 16'd8) : len_err_q;
  assign hdr_err_s     = short_ref_s | (data[31:16] != len_ref_s);
  assign bytes_next_s  = (bytes_left_q > NB16) ? bytes_left_q - NB16 : 16'd0;
  assign keep8_s       = keep_mask(bytes_left_q);
  assign keep_s        = keep8_s[7 -: NB];

  assign abort_s    = start && ((state_q == ST_HDR2) || (state_q == ST_PAYLOAD));
  assign hdr_last_s = ONE_HDR ? start : ((state_q == ST_HDR2) && in_valid && !start);
  assign pay_s      = (state_q == ST_PAYLOAD) && in_valid && !start;

  // Lowest-index enabled listen entry matching the destination port
  always_comb begin
    logic found;
    logic match;
    found = 1'b0;
    match = 1'b0;
    hit_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      match    = (listen_ports[16*i +: 16] != 16'h0000)
                 && (listen_ports[16*i +: 16] == hdr_sel_s[15:0]);
      hit_s[i] = match & ~found;
      found    = found | match;
    end
  end

`ifdef UDP_RX_CHECKSUM_EN
  logic [15:0] pseudo_s, csum_rx_q, csum_rx_d;
  logic [NB-1:0] csum_keep_s;

  assign pseudo_s = csum_fold({4'd0, src_ip[31:16]} + {4'd0, src_ip[15:0]}
                            + {4'd0, dest_ip[31:16]} + {4'd0, dest_ip[15:0]}
                            + {12'd0, IP_PROTO_UDP} + {4'd0, len_udp});
  assign csum_keep_s = pay_s ? keep_s : {NB{1'b1}};
  assign csum_rx_d   = hdr_last_s ? data[15:0] : csum_rx_q;

  udp_csum_accum #(.DATA_W(DATA_W)) u_csum (
    .clk       (clk),
    .reset     (reset),
    .load_i    (start),
    .en_i      (start | hdr_last_s | pay_s),
    .init_i    (pseudo_s),
    .word_i    (data),
    .keep_i    (csum_keep_s),
    .rx_csum_i (csum_rx_d),
    .pass_o    (csum_pass_s)
  );

  // Received checksum field, held for the end-of-datagram decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_rx_q <= 16'h0000;
    end else begin
      csum_rx_q <= csum_rx_d;
    end
  end
`else
  logic unused_ip_s;
  assign unused_ip_s = ^{src_ip, dest_ip};
  assign csum_pass_s = 1'b1;
`endif

  // Next-state and output decode; abort overrides the end-of-datagram verdict
  always_comb begin
    state_d      = (state_q == ST_DONE) ? ST_IDLE : state_q;
    bytes_left_d = bytes_left_q;
    len_udp_d    = len_udp_q;
    hdr0_d       = hdr0_q;
    len_err_d    = len_err_q;
    src_port_d   = src_port_q;
    dest_port_d  = dest_port_q;
    len_data_d   = len_data_q;
    port_hit_d   = port_hit_q;
    data_udp_d   = data_udp_q;
    data_keep_d  = data_keep_q;
    wr_en_d      = 1'b0;
    fin_d        = 1'b0;
    ok_d         = 1'b0;
    err_len_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_HDR2, ST_PAYLOAD: begin
        if (start) begin
          len_udp_d    = len_udp;
          hdr0_d       = data[DATA_W-1 -: 32];
          bytes_left_d = start_bytes_s;
          len_err_d    = (len_udp < 16'd8);
          state_d      = ONE_HDR ? ST_PAYLOAD : ST_HDR2;
        end else begin
          hdr0_d = hdr0_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hdr_last_s) begin
      src_port_d  = hdr_sel_s[31:16];
      dest_port_d = hdr_sel_s[15:0];
      len_data_d  = data[31:16] - 16'd8;
      port_hit_d  = hit_s;
      len_err_d   = hdr_err_s;
      if (bytes_ref_s == 16'd0) begin
        state_d   = ST_DONE;
        fin_d     = 1'b1;
        err_len_d = hdr_err_s;
        ok_d      = csum_pass_s & ~hdr_err_s & (|hit_s);
      end else begin
        state_d = ST_PAYLOAD;
      end
    end else begin
      len_data_d = len_data_d;
    end

    if (pay_s) begin
      data_udp_d   = data;
      data_keep_d  = keep_s;
      wr_en_d      = |port_hit_q;
      bytes_left_d = bytes_next_s;
      if (bytes_next_s == 16'd0) begin
        state_d   = ST_DONE;
        fin_d     = 1'b1;
        err_len_d = len_err_q;
        ok_d      = csum_pass_s & ~len_err_q & (|port_hit_q);
      end else begin
        state_d = ST_PAYLOAD;
      end
    end else begin
      data_udp_d = data_udp_d;
    end

    if (abort_s) begin
      fin_d     = 1'b1;
      ok_d      = 1'b0;
      err_len_d = 1'b0;
      wr_en_d   = 1'b0;
    end else begin
      fin_d = fin_d;
    end
  end

  // State, context and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bytes_left_q <= 16'd0;
      len_udp_q    <= 16'd0;
      hdr0_q       <= 32'd0;
      len_err_q    <= 1'b0;
      src_port_q   <= 16'd0;
      dest_port_q  <= 16'd0;
      len_data_q   <= 16'd0;
      port_hit_q   <= '0;
      data_udp_q   <= '0;
      data_keep_q  <= '0;
      wr_en_q      <= 1'b0;
      fin_q        <= 1'b0;
      ok_q         <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      len_udp_q    <= len_udp_d;
      hdr0_q       <= hdr0_d;
      len_err_q    <= len_err_d;
      src_port_q   <= src_port_d;
      dest_port_q  <= dest_port_d;
      len_data_q   <= len_data_d;
      port_hit_q   <= port_hit_d;
      data_udp_q   <= data_udp_d;
      data_keep_q  <= data_keep_d;
      wr_en_q      <= wr_en_d;
      fin_q        <= fin_d;
      ok_q         <= ok_d;
      err_len_q    <= err_len_d;
    end
  end

  assign src_port  = src_port_q;
  assign dest_port = dest_port_q;
  assign len_data  = len_data_q;
  assign port_hit  = port_hit_q;
  assign data_udp  = data_udp_q;
  assign data_keep = data_keep_q;
  assign wr_en     = wr_en_q;
  assign fin       = fin_q;
  assign ok        = ok_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed bench for udp_rx_parser (DATA_W=32, NUM_PORTS=4) using the
// reference datagram "Hello World" to port 0x2694.
module tb_udp_rx_parser;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [31:0] data, src_ip, dest_ip;
  logic [15:0] len_udp;
  logic [63:0] listen_ports;
  logic [15:0] src_port, dest_port, len_data;
  logic [31:0] data_udp;
  logic [3:0]  data_keep, port_hit;
  logic        wr_en, fin, ok, err_len;

  udp_rx_parser #(.DATA_W(32), .NUM_PORTS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .data(data),
    .src_ip(src_ip), .dest_ip(dest_ip), .len_udp(len_udp), .listen_ports(listen_ports),
    .src_port(src_port), .dest_port(dest_port), .len_data(len_data),
    .data_udp(data_udp), .data_keep(data_keep), .wr_en(wr_en), .port_hit(port_hit),
    .fin(fin), .ok(ok), .err_len(err_len)
  );

  always #5 clk = ~clk;

`ifdef UDP_RX_CHECKSUM_EN
  localparam logic EXP_BAD_OK = 1'b0;
`else
  localparam logic EXP_BAD_OK = 1'b1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fin_cyc;
  logic fin_wr;
  logic [35:0] wr_log[$];
  logic [1:0]  fin_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) wr_log.push_back({data_keep, data_udp});
      if (fin) begin
        fin_log.push_back({ok, err_len});
        fin_cyc <= cyc;
        fin_wr  <= wr_en;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic vld, input logic [31:0] w);
    @(posedge clk);
    #1;
    start    = st;
    in_valid = vld;
    data     = w;
  endtask

  task automatic run_dgram(input int nw, input int gap, input logic [31:0] w1, output int t0);
    logic [31:0] ws [5];
    ws = '{32'ha08f2694, w1, 32'h48656c6c, 32'h6f20576f, 32'h726c6400};
    wr_log.delete();
    fin_log.delete();
    t0 = 0;
    for (int k = 0; k < nw; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 32'hdeadbeef);
      end
      drive(k == 0, 1'b1, ws[k]);
      if (k == 0) t0 = cyc;
    end
    repeat (6) drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_payload(input string tag);
    logic [35:0] exp [3];
    exp = '{{4'hf, 32'h48656c6c}, {4'hf, 32'h6f20576f}, {4'he, 32'h726c6400}};
    chk({tag, "_nwr"}, 64'(wr_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_log.size()) chk($sformatf("%s_wr%0d", tag, i), 64'(wr_log[i]), 64'(exp[i]));
    end
  endtask

  task automatic check_fin(input string tag, input logic [1:0] okerr, input int lat, input int t0);
    chk({tag, "_nfin"}, 64'(fin_log.size()), 64'd1);
    if (fin_log.size() > 0) begin
      chk({tag, "_okerr"}, 64'(fin_log[0]), 64'(okerr));
      chk({tag, "_lat"}, 64'(fin_cyc - t0), 64'(lat));
    end
  endtask

  initial begin
    int t0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; data = 32'h0;
    src_ip = 32'h9801331b; dest_ip = 32'h980e5e4b; len_udp = 16'd19;
    listen_ports = 64'h0000_0000_2694_0000;
    @(negedge clk);
    chk("rst_fin", 64'(fin), 64'd0);
    chk("rst_wr", 64'(wr_en), 64'd0);
    chk("rst_ok", 64'({ok, err_len}), 64'd0);
    chk("rst_hit", 64'(port_hit), 64'd0);
    chk("rst_hdr", {src_port, dest_port, len_data}, 64'd0);
    drive(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 32'h0);

    // Nominal datagram
    run_dgram(5, 0, 32'h00132560, t0);
    check_payload("nom");
    check_fin("nom", 2'b10, 5, t0);
    chk("nom_finwr", 64'(fin_wr), 64'd1);
    chk("nom_len", 64'(len_data), 64'd11);
    chk("nom_hit", 64'(port_hit), 64'b0010);
    chk("nom_ports", 64'({src_port, dest_port}), 64'ha08f2694);

    // Corrupted checksum field
    run_dgram(5, 0, 32'h00132561, t0);
    check_payload("bad");
    check_fin("bad", {EXP_BAD_OK, 1'b0}, 5, t0);

    // Idle gap between every word
    run_dgram(5, 1, 32'h00132560, t0);
    check_payload("gap");
    check_fin("gap", 2'b10, 9, t0);

    // IP length shorter than a UDP header
    len_udp = 16'd7;
    run_dgram(2, 0, 32'h00132560, t0);
    chk("short_nwr", 64'(wr_log.size()), 64'd0);
    check_fin("short", 2'b01, 2, t0);

    // Zero-payload datagram, checksum not transmitted
    len_udp = 16'd8;
    run_dgram(2, 0, 32'h00080000, t0);
    chk("zero_nwr", 64'(wr_log.size()), 64'd0);
    check_fin("zero", 2'b10, 2, t0);
    chk("zero_len", 64'(len_data), 64'd0);

    // No listen entry enabled
    len_udp = 16'd19;
    listen_ports = 64'h0;
    run_dgram(5, 0, 32'h00132560, t0);
    chk("nolist_nwr", 64'(wr_log.size()), 64'd0);
    chk("nolist_hit", 64'(port_hit), 64'd0);
    check_fin("nolist", 2'b00, 5, t0);

    // Restart during the second payload word
    listen_ports = 64'h0000_0000_2694_0000;
    wr_log.delete();
    fin_log.delete();
    drive(1'b1, 1'b1, 32'ha08f2694);
    drive(1'b0, 1'b1, 32'h00132560);
    drive(1'b0, 1'b1, 32'h48656c6c);
    drive(1'b1, 1'b1, 32'ha08f2694);
    t0 = cyc;
    drive(1'b0, 1'b1, 32'h00132560);
    drive(1'b0, 1'b1, 32'h48656c6c);
    drive(1'b0, 1'b1, 32'h6f20576f);
    drive(1'b0, 1'b1, 32'h726c6400);
    repeat (6) drive(1'b0, 1'b0, 32'h0);
    chk("abort_nwr", 64'(wr_log.size()), 64'd4);
    chk("abort_nfin", 64'(fin_log.size()), 64'd2);
    if (fin_log.size() == 2) begin
      chk("abort_first", 64'(fin_log[0]), 64'b00);
      chk("abort_second", 64'(fin_log[1]), 64'b10);
    end
    chk("abort_lat", 64'(fin_cyc - t0), 64'd5);

    // Reset mid-datagram produces no fin
    wr_log.delete();
    fin_log.delete();
    drive(1'b1, 1'b1, 32'ha08f2694);
    drive(1'b0, 1'b1, 32'h00132560);
    drive(1'b0, 1'b1, 32'h48656c6c);
    drive(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    repeat (6) drive(1'b0, 1'b0, 32'h0);
    chk("rstmid_nfin", 64'(fin_log.size()), 64'd0);
    chk("rstmid_hit", 64'(port_hit), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_rx_parser.md
# udp_rx_parser

Parametrised UDP receive parser sitting between the IPv4 receive stage and the per-port payload buffers. It accepts a datagram as a word stream with an optional idle gap between words, extracts the header, and streams the payload with byte-keep. It also verifies the one's-complement checksum over the pseudo-header, header and payload, and steers the datagram against a runtime listen-port table. It generalises the fixed 32-bit decoder to 32/64-bit datapaths, adds valid-qualified input, length checking, abort-on-restart and port matching.

## Interface
- DATA_W, 32, datapath width in bits; legal values are 32 and 64.
- NUM_PORTS, 4, number of listen-port table entries.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  first header word valid on `data`; implies in_valid.
- in_valid  in  1  qualifies `data` for all subsequent words.
- data  in  DATA_W  datagram word, big-endian, first byte in MSBs.
- src_ip, dest_ip  in  32  pseudo-header IPs, sampled when start=1.
- len_udp  in  16  UDP length from the IP layer, sampled when start=1.
- listen_ports  in  NUM_PORTS*16  entry i is bits [16i+15:16i]; value 0 means the entry is disabled.
- src_port, dest_port, len_data  out  16  header fields; len_data = length − 8.
- data_udp  out  DATA_W  payload word.
- data_keep  out  DATA_W/8  valid-byte mask, MSB first.
- wr_en  out  1  payload word valid.
- port_hit  out  NUM_PORTS  one-hot, lowest matching index.
- fin  out  1  one-cycle end-of-datagram pulse.
- ok  out  1  datagram accepted; meaningful only while fin=1.
- err_len  out  1  length fault; meaningful only while fin=1.

## Operation
- States: IDLE, HDR2 (DATA_W=32 only), PAYLOAD, DONE.
- Transitions:
  - IDLE→HDR2 or PAYLOAD on start.
  - HDR2→PAYLOAD on in_valid.
  - PAYLOAD→DONE when the bytes_left counter reaches 0.
  - DONE→IDLE unconditionally.
- Header layout:
  - DATA_W=32: word0 = {src_port, dest_port}, word1 = {length, checksum}.
  - DATA_W=64: one word {src_port, dest_port, length, checksum}.
- After the header, bytes_left = len_udp − 8. Each accepted payload word subtracts DATA_W/8, saturating at 0.
- The last word's data_keep marks bytes_left bytes from the MSB. Bytes outside the keep are ignored by the checksum.
- Checksum: 16-bit one's-complement sum over src_ip, dest_ip, 16'h0011, len_udp, all header halfwords and the payload. An odd trailing byte is padded with a low 0x00 byte.
- Checksum pass: the folded sum equals 16'hFFFF, or the received checksum is 0 (not transmitted).
- Length faults set err_len and force ok=0:
  - len_udp < 8: header consumed, no payload phase, straight to DONE.
  - Header length field ≠ len_udp: payload still streamed per len_udp.
- Port match: dest_port is compared with every enabled entry. No match means payload words are consumed, wr_en stays low, and ok=0 at fin.
- ok = checksum pass AND no err_len AND port_hit ≠ 0.
- start outside IDLE aborts the current datagram: fin=1, ok=0 on the next cycle. The new header word is accepted on that same edge.
- in_valid=0 stalls the FSM and accumulator with no side effects.

## Timing
- All outputs are registered and reset to 0; the FSM resets to IDLE.
- src_port, dest_port, len_data, port_hit update one cycle after the final header word and hold until the next header.
- wr_en/data_udp/data_keep follow one cycle after the payload word is accepted. There is no back-pressure.
- fin/ok/err_len pulse one cycle after the final accepted word, i.e. in the same cycle as the last wr_en.
- Zero-payload datagrams (len 8) pulse fin one cycle after the header completes.
- Reset mid-datagram discards it; no fin is produced.

## Configuration
- UDP_RX_CHECKSUM_EN
  - Defined: checksum is accumulated and checked as above.
  - Undefined: the accumulator is not built and the checksum pass term is constant 1; length and port rules are unchanged.

## Structure
- Package udp_pkg: UDP_HDR_BYTES=8, IP_PROTO_UDP=8'h11, FSM state typedef, keep-mask function.
- Sub-module udp_csum_accum: per-cycle masked halfword adder (DATA_W/16 lanes, wide intermediate, end-around fold each cycle) and final fold/compare. It is instantiated only under UDP_RX_CHECKSUM_EN.

## Test plan
Common setup for the first three cases: DATA_W=32, src_ip 9801331b, dest_ip 980e5e4b, len_udp 19, listen_ports {0,0,2694,0}. Word stream: a08f2694, 00132560, 48656c6c, 6f20576f, 726c6400.
- Nominal: three wr_en with keep 1111, 1111, 1110; len_data 11; port_hit 0010; fin with ok=1.
- Checksum field changed to 2561 → fin with ok=0, err_len=0.
- Gaps: same stream with in_valid=0 inserted between every word → identical outputs, delayed by the gaps.
- len_udp 7 → no wr_en; fin with ok=0, err_len=1.
- Listen table all zero → no wr_en; port_hit 0; fin with ok=0.
- start during the second payload word, then a full valid datagram → abort fin (ok=0) first; the second datagram reports ok=1.
